// File: rtl/accum_reducer_pkg.sv
// Shared types and constant helpers for the multi-lane reduction accumulator.
package accum_reducer_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

  // Widest accumulator the saturation-bound helpers can describe.
  localparam int MAX_ACC_W = 64;

  function automatic int calc_len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic logic [MAX_ACC_W:0] sat_max(input int acc_w, input bit is_signed);
    logic [MAX_ACC_W:0] v;
    v = '0;
    for (int i = 0; i <= MAX_ACC_W; i++) begin
      if (i < acc_w - int'(is_signed)) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Signed minimum is returned sign-extended; unsigned minimum is zero.
  function automatic logic [MAX_ACC_W:0] sat_min(input int acc_w, input bit is_signed);
    logic [MAX_ACC_W:0] v;
    v = '0;
    for (int i = 0; i <= MAX_ACC_W; i++) begin
      if (is_signed && i >= acc_w - 1) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/accum_reducer_if.sv
// Input beat stream and frame result stream of the reduction accumulator.
interface accum_reducer_if
  import accum_reducer_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int LANES  = 4,
  parameter int ACC_W  = 32,
  parameter int LEN_W  = calc_len_w(256)
);
  logic [LEN_W-1:0]        cfg_len;
  logic [LANES*DATA_W-1:0] in_data;
  logic                    in_last;
  logic                    in_valid;
  logic                    in_ready;
  logic [ACC_W-1:0]        out_sum;
  logic [LEN_W-1:0]        out_beats;
  logic                    out_ovf;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output cfg_len, in_data, in_last, in_valid, out_ready,
    input  in_ready, out_sum, out_beats, out_ovf, out_valid
  );

  modport slave (
    input  cfg_len, in_data, in_last, in_valid, out_ready,
    output in_ready, out_sum, out_beats, out_ovf, out_valid
  );
endinterface

// File: rtl/accum_reducer_lane_adder_tree.sv
// Combinational extend-and-sum of all lanes of one input beat.
module lane_adder_tree #(
  parameter int LANES  = 4,
  parameter int DATA_W = 16,
  parameter int OUT_W  = 33,
  parameter bit SIGNED = 1'b1
) (
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic [OUT_W-1:0]        sum
);
  logic [DATA_W-1:0] lane;
  logic [OUT_W-1:0]  ext;

  // OUT_W leaves headroom for LANES lanes, so the running sum never wraps.
  always_comb begin
    sum  = '0;
    lane = '0;
    ext  = '0;
    for (int i = 0; i < LANES; i++) begin
      lane = in_data[i*DATA_W +: DATA_W];
      ext  = {{(OUT_W-DATA_W){SIGNED & lane[DATA_W-1]}}, lane};
      sum  = sum + ext;
    end
  end
endmodule

// File: rtl/accum_reducer.sv
// Multi-lane reduction accumulator: sums LANES products per beat across a
// frame of up to MAX_LEN beats and emits one registered result per frame.
module accum_reducer
  import accum_reducer_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int LANES   = 4,
  parameter int ACC_W   = 32,
  parameter int MAX_LEN = 256,
  parameter bit SIGNED  = 1'b1,
  parameter bit SAT     = 1'b0
) (
  input logic            clk,
  input logic            rst_n,
  accum_reducer_if.slave bus
);
  localparam int LEN_W = calc_len_w(MAX_LEN);
  localparam logic [MAX_ACC_W:0] HI_FULL = sat_max(ACC_W, SIGNED);
  localparam logic [MAX_ACC_W:0] LO_FULL = sat_min(ACC_W, SIGNED);
  localparam logic [ACC_W-1:0] SAT_HI = HI_FULL[ACC_W-1:0];
  localparam logic [ACC_W-1:0] SAT_LO = LO_FULL[ACC_W-1:0];
  localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt, acc_beat;
  logic [LEN_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [LEN_W-1:0] len_q, len_nxt, len_eff, len_use;
  logic             ovf, ovf_nxt;
  logic [ACC_W:0]   beat_sum, base, total;
  logic             beat_ovf, accept, is_last, load_out;

  lane_adder_tree #(
    .LANES (LANES),
    .DATA_W(DATA_W),
    .OUT_W (ACC_W + 1),
    .SIGNED(SIGNED)
  ) u_tree (
    .in_data(bus.in_data),
    .sum    (beat_sum)
  );

  assign bus.in_ready = (state != OUT);
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    len_eff = bus.cfg_len;
    if (bus.cfg_len == '0)            len_eff = LEN_W'(1);
    else if (bus.cfg_len > MAX_LEN_V) len_eff = MAX_LEN_V;
  end

  // The first beat of a frame starts from zero regardless of leftover acc/cnt.
  assign len_use = (state == IDLE) ? len_eff : len_q;
  assign cnt_inc = (state == IDLE) ? LEN_W'(1) : cnt + LEN_W'(1);
  assign base    = (state == IDLE) ? '0 : {SIGNED & acc[ACC_W-1], acc};
  assign total   = base + beat_sum;
  assign is_last = (cnt_inc == len_use) || bus.in_last;

  always_comb begin
    beat_ovf = SIGNED ? (total[ACC_W] != total[ACC_W-1]) : total[ACC_W];
    acc_beat = total[ACC_W-1:0];
    if (SAT && beat_ovf) begin
      acc_beat = (SIGNED && total[ACC_W]) ? SAT_LO : SAT_HI;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    len_nxt   = len_q;
    ovf_nxt   = ovf;
    load_out  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          len_nxt   = len_eff;
          acc_nxt   = acc_beat;
          cnt_nxt   = cnt_inc;
          ovf_nxt   = beat_ovf;
          load_out  = is_last;
          state_nxt = is_last ? OUT : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_nxt   = acc_beat;
          cnt_nxt   = cnt_inc;
          ovf_nxt   = ovf | beat_ovf;
          load_out  = is_last;
          state_nxt = is_last ? OUT : ACCUM;
        end
      end
      OUT: begin
        if (bus.out_valid && bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      len_q <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      len_q <= len_nxt;
      ovf   <= ovf_nxt;
    end
  end

  // Result registers keep their last values after the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_sum   <= '0;
      bus.out_beats <= '0;
      bus.out_ovf   <= 1'b0;
      bus.out_valid <= 1'b0;
    end else if (load_out) begin
      bus.out_sum   <= acc_nxt;
      bus.out_beats <= cnt_nxt;
      bus.out_ovf   <= ovf_nxt;
      bus.out_valid <= 1'b1;
    end else if (state == OUT && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_accum_reducer.sv
// Scoreboard bench: three accumulators (wrap/32b, sat/20b, wrap/20b) share one
// stimulus stream and are checked against an integer reference model.
module tb_accum_reducer;
  import accum_reducer_pkg::*;

  localparam int DATA_W  = 16;
  localparam int LANES   = 4;
  localparam int MAX_LEN = 256;
  localparam int LEN_W   = calc_len_w(MAX_LEN);
  localparam int ACC_W_A = 32;
  localparam int ACC_W_B = 20;
  localparam int ACC_W_C = 20;

  typedef logic [LANES*DATA_W-1:0] vec_t;
  typedef struct {
    longint sum_a, sum_b, sum_c;
    bit     ovf_a, ovf_b, ovf_c;
    int     beats;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [LEN_W-1:0] cfg_len = '0;
  vec_t in_data = '0;
  logic in_last = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;

  int   n_vec = 0;
  int   n_err = 0;
  int   ready_mode = 1;
  bit   gaps = 1'b0;
  exp_t expq[$];

  always #5 clk = ~clk;

  accum_reducer_if #(.DATA_W(DATA_W), .LANES(LANES), .ACC_W(ACC_W_A), .LEN_W(LEN_W)) bus_a ();
  accum_reducer_if #(.DATA_W(DATA_W), .LANES(LANES), .ACC_W(ACC_W_B), .LEN_W(LEN_W)) bus_b ();
  accum_reducer_if #(.DATA_W(DATA_W), .LANES(LANES), .ACC_W(ACC_W_C), .LEN_W(LEN_W)) bus_c ();

  assign bus_a.cfg_len = cfg_len;   assign bus_b.cfg_len = cfg_len;   assign bus_c.cfg_len = cfg_len;
  assign bus_a.in_data = in_data;   assign bus_b.in_data = in_data;   assign bus_c.in_data = in_data;
  assign bus_a.in_last = in_last;   assign bus_b.in_last = in_last;   assign bus_c.in_last = in_last;
  assign bus_a.in_valid = in_valid; assign bus_b.in_valid = in_valid; assign bus_c.in_valid = in_valid;
  assign bus_a.out_ready = out_ready;
  assign bus_b.out_ready = out_ready;
  assign bus_c.out_ready = out_ready;

  accum_reducer #(.DATA_W(DATA_W), .LANES(LANES), .ACC_W(ACC_W_A), .MAX_LEN(MAX_LEN),
                  .SIGNED(1'b1), .SAT(1'b0))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  accum_reducer #(.DATA_W(DATA_W), .LANES(LANES), .ACC_W(ACC_W_B), .MAX_LEN(MAX_LEN),
                  .SIGNED(1'b1), .SAT(1'b1))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));
  accum_reducer #(.DATA_W(DATA_W), .LANES(LANES), .ACC_W(ACC_W_C), .MAX_LEN(MAX_LEN),
                  .SIGNED(1'b1), .SAT(1'b0))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c.slave));

  function automatic longint mask(input int w);
    return (longint'(1) << w) - 1;
  endfunction

  task automatic cmp(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: exact integer sum per beat, range-checked against the signed
  // ACC_W window, then clamped or wrapped back into it.
  function automatic longint reduce(input vec_t beats[$], input int n, input int acc_w,
                                    input bit sat, output bit ovf);
    longint hi, lo, span, acc, t;
    hi   = (longint'(1) << (acc_w - 1)) - 1;
    lo   = -(longint'(1) << (acc_w - 1));
    span = longint'(1) << acc_w;
    acc  = 0;
    ovf  = 1'b0;
    for (int k = 0; k < n; k++) begin
      t = acc;
      for (int i = 0; i < LANES; i++) begin
        t += longint'($signed(beats[k][i*DATA_W +: DATA_W]));
      end
      if (t > hi || t < lo) begin
        ovf = 1'b1;
        if (sat) t = (t > hi) ? hi : lo;
        else     t = (((t - lo) % span) + span) % span + lo;
      end
      acc = t;
    end
    return acc;
  endfunction

  function automatic vec_t packLanes(input int l0, input int l1, input int l2, input int l3);
    return {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
  endfunction

  function automatic vec_t randVec(input int mode);
    vec_t v;
    for (int i = 0; i < LANES; i++) begin
      case (mode)
        1:       v[i*DATA_W +: DATA_W] = 16'($urandom_range(16'h6000, 16'h7FFF));
        2:       v[i*DATA_W +: DATA_W] = 16'($urandom_range(16'h8000, 16'h9FFF));
        default: v[i*DATA_W +: DATA_W] = 16'($urandom);
      endcase
    end
    return v;
  endfunction

  // Enters and leaves on a falling edge; holds the beat until it is accepted.
  task automatic applyStimulus(input vec_t d, input logic last, input logic [LEN_W-1:0] cfg,
                               input bit is_final);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    cfg_len  = cfg;
    while (!bus_a.in_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (!bus_a.in_ready) begin
      cmp("in_ready_timeout", 0, 1);
    end else begin
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      if (is_final) cmp("latency_valid", longint'(bus_a.out_valid), 1);
    end
  endtask

  task automatic runFrame(input int cfg, input int last_at, input vec_t data[$]);
    int   eff, nb;
    exp_t e;
    bit   o;
    eff     = (cfg == 0) ? 1 : ((cfg > MAX_LEN) ? MAX_LEN : cfg);
    nb      = (last_at > 0 && last_at < eff) ? last_at : eff;
    e.beats = nb;
    e.sum_a = reduce(data, nb, ACC_W_A, 1'b0, o); e.ovf_a = o;
    e.sum_b = reduce(data, nb, ACC_W_B, 1'b1, o); e.ovf_b = o;
    e.sum_c = reduce(data, nb, ACC_W_C, 1'b0, o); e.ovf_c = o;
    expq.push_back(e);
    for (int k = 0; k < nb; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) @(negedge clk);
      applyStimulus(data[k], (last_at > 0 && k == last_at - 1),
                    (k == 0) ? LEN_W'(cfg) : LEN_W'($urandom), k == nb - 1);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("valid_b", longint'(bus_b.out_valid), 1);
    cmp("valid_c", longint'(bus_c.out_valid), 1);
    cmp("sum_a", longint'(bus_a.out_sum), e.sum_a & mask(ACC_W_A));
    cmp("sum_b", longint'(bus_b.out_sum), e.sum_b & mask(ACC_W_B));
    cmp("sum_c", longint'(bus_c.out_sum), e.sum_c & mask(ACC_W_C));
    cmp("beats_a", longint'(bus_a.out_beats), e.beats);
    cmp("beats_b", longint'(bus_b.out_beats), e.beats);
    cmp("ovf_a", longint'(bus_a.out_ovf), longint'(e.ovf_a));
    cmp("ovf_b", longint'(bus_b.out_ovf), longint'(e.ovf_b));
    cmp("ovf_c", longint'(bus_c.out_ovf), longint'(e.ovf_c));
  endtask

  // Monitor: drives out_ready and checks the held result every cycle it is
  // presented, popping the scoreboard only on the handshake.
  initial begin : monitor
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       out_ready = ($urandom_range(0, 9) < 6);
        1:       out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
      if (!rst_n) continue;
      if (bus_a.out_valid) begin
        if (expq.size() == 0) begin
          cmp("unexpected_result", 1, 0);
        end else begin
          checkOutput(expq[0]);
          if (out_ready) void'(expq.pop_front());
        end
      end
    end
  end

  task automatic checkResetValues(input string tag);
    cmp({tag, "_out_valid"}, longint'(bus_a.out_valid), 0);
    cmp({tag, "_out_sum"},   longint'(bus_a.out_sum), 0);
    cmp({tag, "_out_beats"}, longint'(bus_a.out_beats), 0);
    cmp({tag, "_out_ovf"},   longint'(bus_b.out_ovf), 0);
    cmp({tag, "_in_ready"},  longint'(bus_a.in_ready), 1);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (expq.size() != 0 && g < 5000) begin
      @(negedge clk);
      g++;
    end
    cmp("drain_pending", longint'(expq.size()), 0);
    @(negedge clk);
  endtask

  initial begin : stimulus
    vec_t d[$];
    int   cfg, last_at, mode, nb;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst_n = 1'b1;
    @(negedge clk);
    cmp("in_ready_after_reset", longint'(bus_a.in_ready), 1);

    $display("[TB] directed frames");
    d = {}; repeat (8) d.push_back(packLanes(1, 1, 1, 1));
    runFrame(8, 0, d);
    d = {packLanes(1, -2, 3, -4), packLanes(-1, -1, -1, -1)};
    runFrame(2, 0, d);
    d = {}; repeat (6) d.push_back(packLanes(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF));
    runFrame(6, 0, d);
    d = {}; repeat (8) d.push_back(packLanes(5, 5, 5, 5));
    runFrame(8, 3, d);
    d = {packLanes(7, -3, 2, 9)};
    runFrame(0, 0, d);
    d = {}; repeat (8) d.push_back(packLanes(16'h8000, 16'h8000, 16'h8000, 16'h8000));
    runFrame(8, 0, d);

    $display("[TB] back-pressure hold");
    ready_mode = 2;
    d = {packLanes(100, 200, 300, 400), packLanes(-50, 7, 8, 9)};
    runFrame(2, 0, d);
    fork
      begin
        repeat (6) @(negedge clk);
        ready_mode = 1;
      end
    join_none
    d = {packLanes(3, 3, 3, 3), packLanes(4, 4, 4, 4), packLanes(1, 0, 0, 0)};
    runFrame(3, 0, d);

    $display("[TB] randomized frames");
    ready_mode = 0;
    gaps = 1'b1;
    d = {}; repeat (MAX_LEN) d.push_back(randVec(0));
    runFrame(300, 0, d);
    for (int f = 0; f < 30; f++) begin
      cfg     = $urandom_range(0, 20);
      mode    = $urandom_range(0, 2);
      last_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 0;
      nb      = (cfg == 0) ? 1 : cfg;
      d = {}; repeat (nb) d.push_back(randVec(mode));
      runFrame(cfg, last_at, d);
    end
    gaps = 1'b0;
    ready_mode = 1;
    drain();

    $display("[TB] reset mid-frame");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(packLanes(9, 9, 9, 9), 1'b0, (k == 0) ? LEN_W'(8) : LEN_W'(0), 1'b0);
    end
    rst_n = 1'b0;
    #1;
    checkResetValues("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    d = {packLanes(1, 1, 1, 1), packLanes(1, 1, 1, 1)};
    runFrame(2, 0, d);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
